// File: rtl/hazard_pkg.sv
// hazard_pkg
// Shared types and constants for the pipeline hazard controller:
//   state_t        controller FSM states
//   DRAIN_MAX      largest legal interrupt drain length (bubble cycles)
//   CNT_W          drain counter width, sized for DRAIN_MAX
//   REG_W_DEFAULT  default register index width
package hazard_pkg;

  localparam int DRAIN_MAX     = 7;
  localparam int CNT_W         = $clog2(DRAIN_MAX + 1);
  localparam int REG_W_DEFAULT = 3;

  typedef enum logic [2:0] {
    S_RUN         = 3'd0,
    S_INT_DRAIN   = 3'd1,
    S_INT_PUSH_HI = 3'd2,
    S_INT_PUSH_LO = 3'd3,
    S_INT_VECTOR  = 3'd4,
    S_RET_WAIT    = 3'd5
  } state_t;

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// pipeline_hazard_controller_if
// Bundles the pipeline-status inputs and buffer-control outputs of the
// hazard controller.
//   master : pipeline side, drives the i_* status, observes the o_* controls
//   slave  : controller side, reads the i_* status, drives the o_* controls
interface pipeline_hazard_controller_if
  import hazard_pkg::*;
#(
  parameter int REG_W = REG_W_DEFAULT
);

  logic [REG_W-1:0] i_fd_rs;
  logic [REG_W-1:0] i_fd_rt;
  logic             i_fd_uses_rs;
  logic             i_fd_uses_rt;
  logic [REG_W-1:0] i_dx_rd;
  logic             i_dx_mem_read;
  logic             i_dx_write_back;
  logic             i_dx_pop_pc;
  logic             i_branch_taken;
  logic             i_pc_loaded;
  logic             i_interrupt;

  logic             o_fetch_enable;
  logic             o_fd_enable;
  logic             o_fd_flush;
  logic             o_dx_enable;
  logic             o_dx_flush;
  logic             o_int_push;
  logic             o_int_push_hi;
  logic             o_load_vector;
  logic             o_busy;

  modport master (
    output i_fd_rs, i_fd_rt, i_fd_uses_rs, i_fd_uses_rt, i_dx_rd,
           i_dx_mem_read, i_dx_write_back, i_dx_pop_pc, i_branch_taken,
           i_pc_loaded, i_interrupt,
    input  o_fetch_enable, o_fd_enable, o_fd_flush, o_dx_enable, o_dx_flush,
           o_int_push, o_int_push_hi, o_load_vector, o_busy
  );

  modport slave (
    input  i_fd_rs, i_fd_rt, i_fd_uses_rs, i_fd_uses_rt, i_dx_rd,
           i_dx_mem_read, i_dx_write_back, i_dx_pop_pc, i_branch_taken,
           i_pc_loaded, i_interrupt,
    output o_fetch_enable, o_fd_enable, o_fd_flush, o_dx_enable, o_dx_flush,
           o_int_push, o_int_push_hi, o_load_vector, o_busy
  );

endinterface

// File: rtl/pipeline_hazard_controller_load_use.sv
// load_use_detector
// Flags a load in execute whose destination is read by the instruction in
// decode. Purely combinational.
//   rs, rt, uses_rs, uses_rt : decode-stage sources and their valid bits
//   rd, mem_read, write_back : execute-stage destination and load/write flags
//   hazard                   : decode must wait one cycle for the load data
module load_use_detector
  import hazard_pkg::*;
#(
  parameter int REG_W = REG_W_DEFAULT
) (
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic             uses_rs,
  input  logic             uses_rt,
  input  logic [REG_W-1:0] rd,
  input  logic             mem_read,
  input  logic             write_back,
  output logic             hazard
);

  // r0 is a normal register here, so no zero-index exclusion.
  assign hazard = mem_read & write_back &
                  ((uses_rs & (rs == rd)) | (uses_rt & (rt == rd)));

endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
// Stall/flush control for the fetch/decode and decode/execute buffers:
// load-use stalls, taken-branch flushes, interrupt entry (drain, two-cycle
// PC push, vector load) and RET/RTI wait for the popped PC.
//   i_clk, i_reset_n : clock, async active-low reset
//   bus (slave)      : pipeline status in, buffer/PC controls out
// Outputs are combinational from state and current inputs so the buffers
// react in the same cycle.
//
//   state         | meaning
//   S_RUN         | normal flow, branch / return / interrupt / load-use checks
//   S_INT_DRAIN   | bubbles before the interrupt PC push
//   S_INT_PUSH_HI | push upper PC half
//   S_INT_PUSH_LO | push lower PC half
//   S_INT_VECTOR  | load PC from the interrupt vector
//   S_RET_WAIT    | wait for the memory stage to return the popped PC
module pipeline_hazard_controller
  import hazard_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2,
  parameter int REG_W        = REG_W_DEFAULT
) (
  input logic                         i_clk,
  input logic                         i_reset_n,
  pipeline_hazard_controller_if.slave bus
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             pend_now;
  logic             hazard;

  logic fetch_en, fd_en, fd_fl, dx_en, dx_fl, push, push_hi, load_vec;

  load_use_detector #(.REG_W(REG_W)) u_load_use (
    .rs         (bus.i_fd_rs),
    .rt         (bus.i_fd_rt),
    .uses_rs    (bus.i_fd_uses_rs),
    .uses_rt    (bus.i_fd_uses_rt),
    .rd         (bus.i_dx_rd),
    .mem_read   (bus.i_dx_mem_read),
    .write_back (bus.i_dx_write_back),
    .hazard     (hazard)
  );

  // A request seen this cycle counts immediately, so RUN can react to it.
  assign pend_now = pend_q | bus.i_interrupt;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fetch_en = 1'b1;
    fd_en    = 1'b1;
    fd_fl    = 1'b0;
    dx_en    = 1'b1;
    dx_fl    = 1'b0;
    push     = 1'b0;
    push_hi  = 1'b0;
    load_vec = 1'b0;

    case (state_q)
      S_RUN: begin
        if (bus.i_branch_taken) begin
          fd_fl = 1'b1;
          dx_fl = 1'b1;
        end else if (bus.i_dx_pop_pc) begin
          fetch_en = 1'b0;
          fd_fl    = 1'b1;
          dx_fl    = 1'b1;
          state_d  = S_RET_WAIT;
        end else if (pend_now) begin
          // Execute keeps its instruction; only the younger fetch is dropped.
          fetch_en = 1'b0;
          fd_fl    = 1'b1;
          cnt_d    = CNT_W'(DRAIN_CYCLES - 1);
          state_d  = S_INT_DRAIN;
        end else if (hazard) begin
          fetch_en = 1'b0;
          fd_en    = 1'b0;
          dx_fl    = 1'b1;
        end
      end
      S_INT_DRAIN: begin
        fetch_en = 1'b0;
        fd_fl    = 1'b1;
        dx_fl    = 1'b1;
        if (cnt_q == '0) state_d = S_INT_PUSH_HI;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_INT_PUSH_HI: begin
        fetch_en = 1'b0;
        fd_fl    = 1'b1;
        dx_fl    = 1'b1;
        push     = 1'b1;
        push_hi  = 1'b1;
        state_d  = S_INT_PUSH_LO;
      end
      S_INT_PUSH_LO: begin
        fetch_en = 1'b0;
        fd_fl    = 1'b1;
        dx_fl    = 1'b1;
        push     = 1'b1;
        state_d  = S_INT_VECTOR;
      end
      S_INT_VECTOR: begin
        load_vec = 1'b1;
        fd_fl    = 1'b1;
        dx_fl    = 1'b1;
        state_d  = S_RUN;
      end
      S_RET_WAIT: begin
        fetch_en = bus.i_pc_loaded;
        fd_fl    = 1'b1;
        dx_fl    = 1'b1;
        if (bus.i_pc_loaded) state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase

    // Held in reset: freeze everything and keep both buffers cleared.
    if (!i_reset_n) begin
      fetch_en = 1'b0;
      fd_en    = 1'b0;
      dx_en    = 1'b0;
      fd_fl    = 1'b1;
      dx_fl    = 1'b1;
      push     = 1'b0;
      push_hi  = 1'b0;
      load_vec = 1'b0;
    end
  end

  assign pend_d = (state_d == S_INT_VECTOR) ? 1'b0 : pend_now;

  assign bus.o_fetch_enable = fetch_en;
  assign bus.o_fd_enable    = fd_en;
  assign bus.o_fd_flush     = fd_fl;
  assign bus.o_dx_enable    = dx_en;
  assign bus.o_dx_flush     = dx_fl;
  assign bus.o_int_push     = push;
  assign bus.o_int_push_hi  = push_hi;
  assign bus.o_load_vector  = load_vec;
  assign bus.o_busy         = (state_q != S_RUN);

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller
// Scoreboard bench: each driven cycle queues its expected output vector
// (with a mask of the outputs that matter in that cycle); the negedge
// monitor pops and compares.
// Output vector bit order:
//   [8] fetch_enable [7] fd_enable [6] fd_flush [5] dx_enable [4] dx_flush
//   [3] int_push [2] int_push_hi [1] load_vector [0] busy
module tb_pipeline_hazard_controller;

  localparam logic [8:0] M_ALL  = 9'b1_1_1_1_1_1_1_1_1;
  localparam logic [8:0] M_CTL  = 9'b1_0_1_0_1_1_1_1_1;
  localparam logic [8:0] M_HAZ  = 9'b1_1_0_0_1_1_1_1_1;
  localparam logic [8:0] M_INT  = 9'b1_0_1_0_0_1_1_1_1;

  localparam logic [8:0] E_RST  = 9'b0_0_1_0_1_0_0_0_0;
  localparam logic [8:0] E_RUN  = 9'b1_1_0_1_0_0_0_0_0;
  localparam logic [8:0] E_HAZ  = 9'b0_0_0_0_1_0_0_0_0;
  localparam logic [8:0] E_BR   = 9'b1_1_1_1_1_0_0_0_0;
  localparam logic [8:0] E_POP  = 9'b0_0_1_0_1_0_0_0_0;
  localparam logic [8:0] E_INT  = 9'b0_0_1_0_0_0_0_0_0;
  localparam logic [8:0] E_DRN  = 9'b0_0_1_0_1_0_0_0_1;
  localparam logic [8:0] E_HI   = 9'b0_0_1_0_1_1_1_0_1;
  localparam logic [8:0] E_LO   = 9'b0_0_1_0_1_1_0_0_1;
  localparam logic [8:0] E_VEC  = 9'b1_0_1_0_1_0_0_1_1;
  localparam logic [8:0] E_RETW = 9'b0_0_1_0_1_0_0_0_1;
  localparam logic [8:0] E_RETL = 9'b1_0_1_0_1_0_0_0_1;

  typedef struct {
    string      tag;
    logic [8:0] e;
    logic [8:0] m;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  exp_t sb[$];

  pipeline_hazard_controller_if #(.REG_W(3)) bus ();

  pipeline_hazard_controller #(.DRAIN_CYCLES(2), .REG_W(3)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus.slave)
  );

  wire [8:0] obs = {bus.o_fetch_enable, bus.o_fd_enable, bus.o_fd_flush,
                    bus.o_dx_enable, bus.o_dx_flush, bus.o_int_push,
                    bus.o_int_push_hi, bus.o_load_vector, bus.o_busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%b want=%b", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      check(x.tag, obs & x.m, x.e & x.m);
    end
  end

  task automatic step(input string tag,
                      input logic [2:0] rs, input logic [2:0] rt,
                      input logic urs, input logic urt, input logic [2:0] rd,
                      input logic mr, input logic wb, input logic pop,
                      input logic br, input logic pcl, input logic irq,
                      input logic [8:0] e, input logic [8:0] m);
    exp_t x;
    @(posedge clk);
    #1;
    bus.i_fd_rs         = rs;
    bus.i_fd_rt         = rt;
    bus.i_fd_uses_rs    = urs;
    bus.i_fd_uses_rt    = urt;
    bus.i_dx_rd         = rd;
    bus.i_dx_mem_read   = mr;
    bus.i_dx_write_back = wb;
    bus.i_dx_pop_pc     = pop;
    bus.i_branch_taken  = br;
    bus.i_pc_loaded     = pcl;
    bus.i_interrupt     = irq;
    x.tag = tag;
    x.e   = e;
    x.m   = m;
    sb.push_back(x);
  endtask

  task automatic idle(input string tag, input logic [8:0] e, input logic [8:0] m);
    step(tag, 3'd1, 3'd2, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e, m);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.i_fd_rs = '0; bus.i_fd_rt = '0; bus.i_fd_uses_rs = 1'b0;
    bus.i_fd_uses_rt = 1'b0; bus.i_dx_rd = '0; bus.i_dx_mem_read = 1'b0;
    bus.i_dx_write_back = 1'b0; bus.i_dx_pop_pc = 1'b0;
    bus.i_branch_taken = 1'b0; bus.i_pc_loaded = 1'b0; bus.i_interrupt = 1'b0;

    #1 check("reset_out", obs, E_RST);
    #21 rst_n = 1'b1;

    idle("run_idle0", E_RUN, M_ALL);
    idle("run_idle1", E_RUN, M_ALL);

    // load-use on rs, then bubble in execute
    step("lu_rs",     3'd3, 3'd6, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_HAZ, M_HAZ);
    step("lu_bubble", 3'd3, 3'd6, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN, M_ALL);
    // same indices but rs not read
    step("lu_nouse",  3'd3, 3'd6, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN, M_ALL);
    // r0 on rt
    step("lu_r0_rt",  3'd4, 3'd0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_HAZ, M_HAZ);
    step("lu_r0_bub", 3'd4, 3'd0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN, M_ALL);
    // load without write-back
    step("lu_nowb",   3'd3, 3'd3, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN, M_ALL);
    // non-load write
    step("lu_nomr",   3'd3, 3'd3, 1'b1, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN, M_ALL);
    // branch wins over load-use
    step("br_haz",    3'd3, 3'd6, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, E_BR, M_ALL);
    idle("br_after", E_RUN, M_ALL);

    // interrupt entry, branch during drain is ignored
    step("int_take",  3'd1, 3'd2, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, E_INT, M_INT);
    idle("int_drn0", E_DRN, M_CTL);
    step("int_drn1",  3'd1, 3'd2, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, E_DRN, M_CTL);
    idle("int_hi",   E_HI,  M_CTL);
    idle("int_lo",   E_LO,  M_CTL);
    idle("int_vec",  E_VEC, M_CTL);
    idle("int_run",  E_RUN, M_ALL);
    idle("int_run2", E_RUN, M_ALL);

    // return with interrupt arriving during the wait
    step("ret_pop",   3'd1, 3'd2, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, E_POP, M_CTL);
    idle("ret_w1", E_RETW, M_CTL);
    step("ret_w2_irq", 3'd1, 3'd2, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, E_RETW, M_CTL);
    idle("ret_w3", E_RETW, M_CTL);
    step("ret_load",  3'd1, 3'd2, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_RETL, M_CTL);
    idle("ret_int_take", E_INT, M_INT);
    idle("ret_int_drn0", E_DRN, M_CTL);
    idle("ret_int_drn1", E_DRN, M_CTL);
    idle("ret_int_hi",   E_HI,  M_CTL);

    // async reset in the middle of PUSH_HI
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("rst_async", obs, E_RST);
    @(posedge clk);
    #1 check("rst_hold", obs, E_RST);
    #2 rst_n = 1'b1;

    idle("post_rst0", E_RUN, M_ALL);
    idle("post_rst1", E_RUN, M_ALL);
    idle("post_rst2", E_RUN, M_ALL);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Sequences the fetch/decode and decode/execute pipeline buffers of the 16-bit RISC pipeline.
- Generates the per-stage enable (stall) and flush controls for those buffers.
- Detects load-use hazards and applies taken-branch flushes.
- Runs a multi-cycle interrupt entry sequence (drain, 2-cycle PC push, vector load) and a return wait for the PC pop.

Parameters:
- DRAIN_CYCLES, 2: bubble cycles inserted before interrupt PC push; legal range 1..7.
- REG_W, 3: register index width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_fd_rs  in  REG_W  decode-stage source 1 index.
- i_fd_rt  in  REG_W  decode-stage source 2 index.
- i_fd_uses_rs  in  1  decode instruction reads rs.
- i_fd_uses_rt  in  1  decode instruction reads rt.
- i_dx_rd  in  REG_W  execute-stage destination index.
- i_dx_mem_read  in  1  execute-stage instruction is a load.
- i_dx_write_back  in  1  execute-stage instruction writes a register.
- i_dx_pop_pc  in  1  execute-stage instruction is RET/RTI.
- i_branch_taken  in  1  execute stage resolved a taken branch this cycle.
- i_pc_loaded  in  1  memory stage finished loading the popped PC (1-cycle pulse).
- i_interrupt  in  1  external interrupt request (level).
- o_fetch_enable  out  1  PC/fetch advance.
- o_fd_enable  out  1  fetch/decode buffer enable.
- o_fd_flush  out  1  fetch/decode buffer clear.
- o_dx_enable  out  1  decode/execute buffer enable.
- o_dx_flush  out  1  decode/execute buffer clear (bubble).
- o_int_push  out  1  push PC half this cycle.
- o_int_push_hi  out  1  1 = upper PC half, 0 = lower.
- o_load_vector  out  1  load PC from interrupt vector.
- o_busy  out  1  FSM not in RUN.

Behaviour:
- Reset (i_reset_n low, asynchronous):
  - State goes to RUN; interrupt pending is cleared; drain counter is cleared.
  - While reset is asserted: all enables are 0, o_fd_flush and o_dx_flush are 1, and all other outputs are 0.
- Registered state and combinational outputs:
  - States are RUN, INT_DRAIN, INT_PUSH_HI, INT_PUSH_LO, INT_VECTOR and RET_WAIT.
  - Outputs decode combinationally from the state and the current inputs, so there is zero-cycle latency to the buffers.
- Pending interrupt:
  - Set on any cycle with i_interrupt high.
  - Cleared on entry to INT_VECTOR.
  - A request arriving while not in RUN stays pending.
- RUN priority, highest first:
  - (1) i_branch_taken: o_fd_flush=1 and o_dx_flush=1; enables stay 1 so the new target is fetched.
  - (2) i_dx_pop_pc: o_fetch_enable=0, o_fd_flush=1, o_dx_flush=1; next state RET_WAIT.
  - (3) Pending interrupt: o_fetch_enable=0, o_fd_flush=1; load the counter with DRAIN_CYCLES-1; next state INT_DRAIN.
  - (4) Load-use hazard, defined as dx_mem_read & dx_write_back & ((uses_rs & rs==rd) | (uses_rt & rt==rd)): o_fetch_enable=0, o_fd_enable=0, o_dx_flush=1 for exactly 1 cycle. The next cycle re-evaluates, and the hazard clears because execute now holds a bubble.
  - (5) Otherwise all enables are 1 and all flushes are 0.
- INT_DRAIN:
  - o_fetch_enable=0, o_fd_flush=1, o_dx_flush=1.
  - Decrement the counter; go to INT_PUSH_HI when the counter is 0.
  - i_branch_taken here is ignored; it is already drained.
- INT_PUSH_HI: fetch stalled, flushes 1, o_int_push=1, o_int_push_hi=1. Next state INT_PUSH_LO.
- INT_PUSH_LO: as INT_PUSH_HI but with o_int_push_hi=0. Next state INT_VECTOR.
- INT_VECTOR:
  - o_load_vector=1, o_fetch_enable=1, o_fd_flush=1, o_dx_flush=1.
  - Next state RUN.
- RET_WAIT:
  - Fetch stalled; fd and dx flushed.
  - Stays until i_pc_loaded, then goes to RUN. In that cycle o_fetch_enable=1.
  - Pending interrupts are serviced after return.
- o_busy = (state != RUN).
- Register index 0 is an ordinary register and participates in hazard compares.

Decomposition:
- Shared package hazard_pkg holds:
  - the state enum;
  - the constant DRAIN_MAX=7;
  - the REG_W default.
- Natural sub-module: load_use_detector, a pure combinational compare that feeds the FSM.

Test Plan:
- Load-use: dx_rd=3 with mem_read=1 and write_back=1; fd_rs=3 with uses_rs=1 -> one cycle of fetch_enable=0, fd_enable=0, dx_flush=1; the following cycle with dx bubble inputs gives all enables 1. Repeat with uses_rs=0 -> no stall.
- Branch plus hazard in the same cycle: i_branch_taken=1 with the load-use condition true -> fd_flush=1, dx_flush=1, fetch_enable=1, no stall.
- Interrupt with DRAIN_CYCLES=2: pulse i_interrupt in RUN -> sequence RUN, DRAIN, DRAIN, PUSH_HI (push=1, hi=1), PUSH_LO (push=1, hi=0), VECTOR (load_vector=1), RUN; o_busy high for 5 cycles.
- Return: i_dx_pop_pc=1, then i_pc_loaded pulsed 4 cycles later -> fetch_enable=0 for 4 cycles, then 1. An i_interrupt pulse during RET_WAIT -> INT_DRAIN starts the cycle after RUN is re-entered.
- Async reset mid-sequence: drop i_reset_n during INT_PUSH_HI -> outputs go to reset values immediately, without a clock edge. After release: RUN, pending=0, no push.
